// File: rtl/mcp_seq_alu.sv
// mcp_seq_alu: registered execute-stage ALU for the multicycle MIPS datapath.
// Single-cycle ops complete on the edge that samples Start. MULT/MULTU/DIV/DIVU
// iterate WL times into HI/LO, then a fix-up cycle applies signs and writes results.
// Handshake: Start is sampled only while Busy=0; Busy is high while an iterative
// op is in flight; Done pulses for exactly one cycle when any op's results land.
module mcp_seq_alu #(
  parameter int WL = 32,
  parameter int SW = $clog2(WL)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Start,
  input  logic [3:0]    ALUSel,
  input  logic [SW-1:0] shamt,
  input  logic [WL-1:0] ALUIN1,
  input  logic [WL-1:0] ALUIN2,
  output logic [WL-1:0] ALUOut,
  output logic [WL-1:0] HI,
  output logic [WL-1:0] LO,
  output logic          Zero,
  output logic          OVF_F,
  output logic          DivZero,
  output logic          Busy,
  output logic          Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [WL-1:0] MOST_NEG = {1'b1, {(WL-1){1'b0}}};

  logic [1:0]      state;
  logic [SW-1:0]   cnt;

  // Captured operation context (op_r: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
  logic [1:0]      op_r;
  logic            s1, s2;
  logic [WL-1:0]   in1_r, in2_r;

  // Multiply datapath
  logic [2*WL-1:0] mc, prod;
  logic [WL-1:0]   mp;

  // Divide datapath
  logic [WL-1:0]   quo, rem, dvsr;

  // Combinational helpers
  logic            is_md, signed_md;
  logic [WL-1:0]   mag1, mag2;
  logic [WL-1:0]   sum, diff, sc_res;
  logic            sc_ovf;
  logic [WL:0]     div_shift, div_trial;
  logic [2*WL-1:0] prod_fix;
  logic [WL-1:0]   fix_hi, fix_lo;
  logic            fix_ovf, fix_dz;

  assign Busy      = (state != S_IDLE);
  assign is_md     = ALUSel[3] & ALUSel[2];
  assign signed_md = ~ALUSel[0];

  // Single-cycle result and overflow from the live operands
  always_comb begin
    sum    = ALUIN1 + ALUIN2;
    diff   = ALUIN1 - ALUIN2;
    sc_res = '0;
    sc_ovf = 1'b0;
    case (ALUSel)
      4'b0000: begin
        sc_res = sum;
        sc_ovf = (ALUIN1[WL-1] == ALUIN2[WL-1]) && (sum[WL-1] != ALUIN1[WL-1]);
      end
      4'b0001: begin
        sc_res = diff;
        sc_ovf = (ALUIN1[WL-1] != ALUIN2[WL-1]) && (diff[WL-1] != ALUIN1[WL-1]);
      end
      4'b0010: sc_res = ALUIN2 << shamt;
      4'b0011: sc_res = ALUIN2 >> shamt;
      4'b0100: sc_res = ALUIN2 << ALUIN1[SW-1:0];
      4'b0101: sc_res = ALUIN2 >> ALUIN1[SW-1:0];
      4'b0110: sc_res = $signed(ALUIN2) >>> ALUIN1[SW-1:0];
      4'b0111: sc_res = ALUIN1 & ALUIN2;
      4'b1000: sc_res = ALUIN1 | ALUIN2;
      4'b1001: sc_res = ALUIN1 ^ ALUIN2;
      4'b1010: sc_res = ~(ALUIN1 ^ ALUIN2);
      4'b1011: sc_res = {{(WL-1){1'b0}}, ($signed(ALUIN1) < $signed(ALUIN2))};
      default: sc_res = '0;
    endcase
  end

  // Operand magnitudes for the signed iterative ops (unsigned ops pass through)
  always_comb begin
    mag1 = (signed_md && ALUIN1[WL-1]) ? (~ALUIN1 + 1'b1) : ALUIN1;
    mag2 = (signed_md && ALUIN2[WL-1]) ? (~ALUIN2 + 1'b1) : ALUIN2;
  end

  // Restoring-division trial subtraction: bring down the next dividend bit
  always_comb begin
    div_shift = {rem, quo[WL-1]};
    div_trial = div_shift - {1'b0, dvsr};
  end

  // Fix-up: sign correction and special cases for the final HI/LO write
  always_comb begin
    prod_fix = prod;
    fix_hi   = '0;
    fix_lo   = '0;
    fix_ovf  = 1'b0;
    fix_dz   = 1'b0;
    if (!op_r[1]) begin
      if (op_r == 2'b00 && (s1 ^ s2)) prod_fix = ~prod + 1'b1;
      fix_hi = prod_fix[2*WL-1:WL];
      fix_lo = prod_fix[WL-1:0];
    end else if (in2_r == '0) begin
      // Divide by zero: quotient saturates, dividend passes through as remainder
      fix_dz = 1'b1;
      fix_lo = '1;
      fix_hi = in1_r;
    end else if (op_r == 2'b10 && in1_r == MOST_NEG && in2_r == '1) begin
      fix_ovf = 1'b1;
      fix_lo  = MOST_NEG;
      fix_hi  = '0;
    end else begin
      fix_lo = (op_r == 2'b10 && (s1 ^ s2)) ? (~quo + 1'b1) : quo;
      fix_hi = (op_r == 2'b10 && s1) ? (~rem + 1'b1) : rem;
    end
  end

  // Control FSM plus all result and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ALUOut  <= '0;
      HI      <= '0;
      LO      <= '0;
      Zero    <= 1'b0;
      OVF_F   <= 1'b0;
      DivZero <= 1'b0;
      Done    <= 1'b0;
      op_r    <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      in1_r   <= '0;
      in2_r   <= '0;
      mc      <= '0;
      mp      <= '0;
      prod    <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (is_md) begin
              state <= S_ITER;
              cnt   <= '0;
              op_r  <= ALUSel[1:0];
              s1    <= signed_md & ALUIN1[WL-1];
              s2    <= signed_md & ALUIN2[WL-1];
              in1_r <= ALUIN1;
              in2_r <= ALUIN2;
              mc    <= {{WL{1'b0}}, mag1};
              mp    <= mag2;
              prod  <= '0;
              quo   <= mag1;
              rem   <= '0;
              dvsr  <= mag2;
            end else begin
              ALUOut  <= sc_res;
              Zero    <= (sc_res == '0);
              OVF_F   <= sc_ovf;
              DivZero <= 1'b0;
              Done    <= 1'b1;
            end
          end
        end
        S_ITER: begin
          if (op_r[1]) begin
            if (!div_trial[WL]) begin
              rem <= div_trial[WL-1:0];
              quo <= {quo[WL-2:0], 1'b1};
            end else begin
              rem <= div_shift[WL-1:0];
              quo <= {quo[WL-2:0], 1'b0};
            end
          end else begin
            if (mp[0]) prod <= prod + mc;
            mc <= mc << 1;
            mp <= mp >> 1;
          end
          if (cnt == SW'(WL - 1)) state <= S_FIX;
          else                    cnt   <= cnt + 1'b1;
        end
        S_FIX: begin
          HI      <= fix_hi;
          LO      <= fix_lo;
          ALUOut  <= fix_lo;
          Zero    <= (fix_lo == '0);
          OVF_F   <= fix_ovf;
          DivZero <= fix_dz;
          Done    <= 1'b1;
          cnt     <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp_seq_alu.sv
// Directed bench for mcp_seq_alu (WL=32): single-cycle ops, iterative
// multiply/divide with latency and Busy/Done checks, ignored Start, mid-op reset.
module tb_mcp_seq_alu;

  localparam int WL = 32;
  localparam int SW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [3:0]    alu_sel;
  logic [SW-1:0] shamt;
  logic [WL-1:0] in1, in2;
  logic [WL-1:0] alu_out, hi, lo;
  logic          zero, ovf, div_zero, busy, done;

  int tests  = 0;
  int failed = 0;

  mcp_seq_alu #(.WL(WL)) dut (
    .CLK    (clk),
    .RST    (rst),
    .Start  (start),
    .ALUSel (alu_sel),
    .shamt  (shamt),
    .ALUIN1 (in1),
    .ALUIN2 (in2),
    .ALUOut (alu_out),
    .HI     (hi),
    .LO     (lo),
    .Zero   (zero),
    .OVF_F  (ovf),
    .DivZero(div_zero),
    .Busy   (busy),
    .Done   (done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation. For iterative ops, optionally pulse an ADD Start
  // inject_at cycles into the busy window and scramble operands afterwards.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [WL-1:0] a,
                        input logic [WL-1:0] b, input logic [SW-1:0] sh, input int inject_at);
    int bad;
    bit md;
    md      = (op[3] && op[2]);
    alu_sel = op;
    in1     = a;
    in2     = b;
    shamt   = sh;
    start   = 1'b1;
    tick();
    start = 1'b0;
    if (!md) begin
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
    end else begin
      check({tag, "_busy_rise"}, busy, 1'b1);
      bad = 0;
      for (int i = 1; i <= WL; i++) begin
        if (i == inject_at) begin
          alu_sel = 4'b0000;
          in1     = 32'h0000_0001;
          in2     = 32'h0000_0001;
          start   = 1'b1;
        end else if (i == inject_at + 1) begin
          start = 1'b0;
          in1   = 32'hDEAD_BEEF;
          in2   = 32'h1234_5678;
        end
        tick();
        if (busy !== 1'b1 || done !== 1'b0) bad++;
      end
      start = 1'b0;
      check({tag, "_busy_window_bad_cycles"}, bad, 0);
      tick();
      check({tag, "_done_at_33"}, done, 1'b1);
      check({tag, "_busy_low"}, busy, 1'b0);
    end
  endtask

  initial begin
    int dcount;
    rst     = 1'b1;
    start   = 1'b0;
    alu_sel = '0;
    shamt   = '0;
    in1     = '0;
    in2     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_aluout", alu_out, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_flags", {zero, ovf, div_zero, busy, done}, 0);

    // ADD overflow
    run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, -1);
    check("add_ovf_res", alu_out, 32'h8000_0000);
    check("add_ovf_flag", ovf, 1'b1);
    check("add_ovf_zero", zero, 1'b0);
    tick();
    check("add_done_drop", done, 1'b0);

    // SUB to zero
    run_op("sub_zero", 4'b0001, 32'd5, 32'd5, 0, -1);
    check("sub_zero_res", alu_out, 0);
    check("sub_zero_zero", zero, 1'b1);
    check("sub_zero_ovf", ovf, 1'b0);

    // SUB overflow: most-negative minus one
    run_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1, 0, -1);
    check("sub_ovf_res", alu_out, 32'h7FFF_FFFF);
    check("sub_ovf_flag", ovf, 1'b1);

    // Shifts
    run_op("lsl", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0003, 5'd4, -1);
    check("lsl_res", alu_out, 32'h0000_0030);
    run_op("lsr", 4'b0011, 32'h0, 32'h8000_0000, 5'd31, -1);
    check("lsr_res", alu_out, 32'h0000_0001);
    run_op("lsvl", 4'b0100, 32'h0000_0021, 32'h8000_0001, 5'd0, -1);
    check("lsvl_res", alu_out, 32'h0000_0002);
    run_op("asvr", 4'b0110, 32'h0000_0024, 32'h8000_0000, 5'd0, -1);
    check("asvr_res", alu_out, 32'hF800_0000);

    // Logic and compare
    run_op("xnor", 4'b1010, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, -1);
    check("xnor_res", alu_out, 32'hF00F_F00F);
    run_op("slt_t", 4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, -1);
    check("slt_t_res", alu_out, 32'd1);
    run_op("slt_f", 4'b1011, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, -1);
    check("slt_f_res", alu_out, 32'd0);
    check("slt_f_zero", zero, 1'b1);

    // MULT -3 x 5
    run_op("mult", 4'b1100, 32'hFFFF_FFFD, 32'd5, 5'd0, -1);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    check("mult_aluout", alu_out, 32'hFFFF_FFF1);
    check("mult_flags", {zero, ovf, div_zero}, 3'b000);

    // MULTU 0xFFFFFFFF x 2
    run_op("multu", 4'b1101, 32'hFFFF_FFFF, 32'd2, 5'd0, -1);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2
    run_op("div", 4'b1110, 32'hFFFF_FFF9, 32'd2, 5'd0, -1);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_ovf", ovf, 1'b0);

    // DIV most-negative / -1
    run_op("div_ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, -1);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);
    check("div_ovf_flag", ovf, 1'b1);

    // DIVU 10 / 0, followed immediately by an ADD issued in the Done cycle
    run_op("divz", 4'b1111, 32'd10, 32'd0, 5'd0, -1);
    check("divz_lo", lo, 32'hFFFF_FFFF);
    check("divz_hi", hi, 32'h0000_000A);
    check("divz_flag", div_zero, 1'b1);
    run_op("add_after", 4'b0000, 32'd1, 32'd1, 5'd0, -1);
    check("add_after_res", alu_out, 32'd2);
    check("add_after_dz_clr", div_zero, 1'b0);
    check("add_after_hi_hold", hi, 32'h0000_000A);
    check("add_after_lo_hold", lo, 32'hFFFF_FFFF);

    // ADD Start during MULT busy window is ignored
    run_op("mult_inj", 4'b1100, 32'd6, 32'd7, 5'd0, 5);
    check("mult_inj_lo", lo, 32'd42);
    check("mult_inj_hi", hi, 32'd0);
    check("mult_inj_aluout", alu_out, 32'd42);
    tick();
    check("mult_inj_done_drop", done, 1'b0);
    check("mult_inj_hold", alu_out, 32'd42);

    // Reset 10 cycles into a MULT aborts it
    alu_sel = 4'b1101;
    in1     = 32'd3;
    in2     = 32'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_hi", hi, 0);
    check("rstmid_lo", lo, 0);
    check("rstmid_done", done, 1'b0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) dcount++;
    end
    check("rstmid_no_done", dcount, 0);
    check("rstmid_lo_stay", lo, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
